// File: rtl/cv32e40x_rf_wport_arbiter.sv
// ---------------------------------------------------------------------------
// cv32e40x_rf_wport_arbiter
//
// This block shares the single register-file write port between two sources:
// the WB-stage write request and coprocessor (X-IF) results. WB wins by
// default. An X-IF result that keeps losing is forced through once its
// starvation counter reaches STARVE_LIMIT. The granted write is registered,
// so the RF write happens one cycle after the grant. Writes to x0 are
// suppressed, but the handshake for that request still completes.
//
// Optional feature (macro CV32E40X_RF_ARB_XIF_BUF_EN):
//   When the macro is defined, a 2-entry FIFO buffers incoming X-IF results.
//   xif_result_ready_o then means "FIFO not full", and the FIFO head competes
//   for the port. Without the macro, the X-IF input competes directly and
//   xif_result_ready_o is its grant.
//
// Parameters:
//   STARVE_LIMIT       consecutive lost cycles before X-IF is forced (1..15)
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   wb_valid_i/wb_we_i/wb_waddr_i/wb_wdata_i  WB-stage write request
//   wb_ready_o         WB request accepted this cycle
//   xif_result_valid_i/_we_i/_rd_i/_data_i    coprocessor result
//   xif_result_ready_o X-IF result handshake completes
//   rf_we_o/rf_waddr_o/rf_wdata_o             register-file write port
// ---------------------------------------------------------------------------
module cv32e40x_rf_wport_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_waddr_i,
  input  logic [31:0] wb_wdata_i,
  output logic        wb_ready_o,
  input  logic        xif_result_valid_i,
  input  logic        xif_result_we_i,
  input  logic [4:0]  xif_result_rd_i,
  input  logic [31:0] xif_result_data_i,
  output logic        xif_result_ready_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic        wb_req;
  logic        xv;
  logic        forced;
  logic        grant_wb;
  logic        grant_xif;
  logic        xh_we;
  logic [4:0]  xh_rd;
  logic [31:0] xh_data;

  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;

`ifdef CV32E40X_RF_ARB_XIF_BUF_EN
  logic [1:0]       fifo_cnt_q;
  logic             rptr_q, wptr_q;
  logic [1:0]       fifo_we_q;
  logic [1:0][4:0]  fifo_rd_q;
  logic [1:0][31:0] fifo_data_q;
  logic             fifo_full;
  logic             push;
  logic             pop;

  assign fifo_full          = (fifo_cnt_q == 2'd2);
  // The ready signal is held low during reset so that no result is taken
  // while the buffer is being cleared. It does not bypass when the FIFO is full.
  assign xif_result_ready_o = !rst && !fifo_full;
  assign push               = xif_result_valid_i && xif_result_ready_o;
  assign pop                = grant_xif;

  // A freshly pushed entry is visible only through fifo_cnt_q. It therefore
  // becomes eligible in the cycle after the push.
  assign xv      = (fifo_cnt_q != 2'd0);
  assign xh_we   = fifo_we_q[rptr_q];
  assign xh_rd   = fifo_rd_q[rptr_q];
  assign xh_data = fifo_data_q[rptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_cnt_q <= 2'd0;
      rptr_q     <= 1'b0;
      wptr_q     <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
      if (push) wptr_q <= ~wptr_q;
      if (pop)  rptr_q <= ~rptr_q;
    end
  end

  // Storage needs no reset; the count and pointers above define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we_q[wptr_q]   <= xif_result_we_i;
      fifo_rd_q[wptr_q]   <= xif_result_rd_i;
      fifo_data_q[wptr_q] <= xif_result_data_i;
    end
  end
`else
  assign xv                 = xif_result_valid_i;
  assign xh_we              = xif_result_we_i;
  assign xh_rd              = xif_result_rd_i;
  assign xh_data            = xif_result_data_i;
  assign xif_result_ready_o = grant_xif;
`endif

  // Arbitration. A WB request that does not write consumes no port slot.
  assign wb_req     = wb_valid_i && wb_we_i;
  assign forced     = xv && (starve_cnt_q == LIMIT);
  assign grant_xif  = xv && (forced || !wb_req);
  assign grant_wb   = wb_req && !forced;
  assign wb_ready_o = !forced;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_xif) begin
      starve_cnt_d = 4'd0;
    end else if (xv && (starve_cnt_q < LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // Write-port register input. Address and data change only on a grant.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_wb) begin
      rf_we_d    = (wb_waddr_i != 5'd0);
      rf_waddr_d = wb_waddr_i;
      rf_wdata_d = wb_wdata_i;
    end else if (grant_xif) begin
      rf_we_d    = xh_we && (xh_rd != 5'd0);
      rf_waddr_d = xh_rd;
      rf_wdata_d = xh_data;
    end
  end

  // Pipeline stage: the grant is registered to the RF write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= 4'd0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= 5'd0;
      rf_wdata_q   <= 32'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;

endmodule

// File: tb/tb_cv32e40x_rf_wport_arbiter.sv
module tb_cv32e40x_rf_wport_arbiter;

  localparam int LIM = 4;
`ifdef CV32E40X_RF_ARB_XIF_BUF_EN
  localparam int FORCE_AT = 5;
`else
  localparam int FORCE_AT = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wbv, wbwe;
  logic [4:0]  wba;
  logic [31:0] wbd;
  logic        wb_ready_o;
  logic        xiv, xiwe;
  logic [4:0]  xird;
  logic [31:0] xid;
  logic        xif_result_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;

  always #5 clk = ~clk;

  cv32e40x_rf_wport_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk                (clk),
    .rst                (rst),
    .wb_valid_i         (wbv),
    .wb_we_i            (wbwe),
    .wb_waddr_i         (wba),
    .wb_wdata_i         (wbd),
    .wb_ready_o         (wb_ready_o),
    .xif_result_valid_i (xiv),
    .xif_result_we_i    (xiwe),
    .xif_result_rd_i    (xird),
    .xif_result_data_i  (xid),
    .xif_result_ready_o (xif_result_ready_o),
    .rf_we_o            (rf_we_o),
    .rf_waddr_o         (rf_waddr_o),
    .rf_wdata_o         (rf_wdata_o)
  );

  typedef struct packed {logic we; logic [4:0] a; logic [31:0] d;} wr_t;
  wr_t exp_q[$];
  wr_t mfifo[$];   // model of buffered X-IF results (used only with the buffer)

  int          n_chk = 0;
  int          n_bad = 0;
  int          m_cnt;
  logic [4:0]  m_a;
  logic [31:0] m_d;
  logic        m_xacc;
  logic        s_wbrdy, s_xrdy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle: inputs were driven just after a falling edge. The model predicts
  // the handshakes and the write; the write is queued and compared after the edge.
  task automatic step();
    logic wbreq, xv, forced, gx, gw, ex_xrdy;
    wr_t  w, h;
    #1;
    wbreq = wbv && wbwe;
`ifdef CV32E40X_RF_ARB_XIF_BUF_EN
    xv = (mfifo.size() != 0);
    h  = xv ? mfifo[0] : '0;
    ex_xrdy = (mfifo.size() < 2);
`else
    xv = xiv;
    h  = '{we: xiwe, a: xird, d: xid};
`endif
    forced = xv && (m_cnt == LIM);
    gx = xv && (forced || !wbreq);
    gw = wbreq && !forced;
`ifndef CV32E40X_RF_ARB_XIF_BUF_EN
    ex_xrdy = gx;
`endif
    s_wbrdy = wb_ready_o;
    s_xrdy  = xif_result_ready_o;
    chk("wb_ready", {31'd0, wb_ready_o}, {31'd0, !forced});
    chk("xif_ready", {31'd0, xif_result_ready_o}, {31'd0, ex_xrdy});
    w = '{we: 1'b0, a: m_a, d: m_d};
    if (gw)      w = '{we: (wba != 5'd0), a: wba, d: wbd};
    else if (gx) w = '{we: h.we && (h.a != 5'd0), a: h.a, d: h.d};
    exp_q.push_back(w);
    m_a = w.a;
    m_d = w.d;
    if (gx) m_cnt = 0;
    else if (xv && m_cnt < LIM) m_cnt++;
`ifdef CV32E40X_RF_ARB_XIF_BUF_EN
    if (gx) void'(mfifo.pop_front());
    m_xacc = xiv && ex_xrdy;
    if (m_xacc) mfifo.push_back('{we: xiwe, a: xird, d: xid});
`else
    m_xacc = gx;
`endif
    @(posedge clk);
    #1;
    w = exp_q.pop_front();
    chk("rf_we", {31'd0, rf_we_o}, {31'd0, w.we});
    chk("rf_waddr", {27'd0, rf_waddr_o}, {27'd0, w.a});
    chk("rf_wdata", rf_wdata_o, w.d);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wbv = 0; wbwe = 0; wba = 0; wbd = 0;
    xiv = 0; xiwe = 0; xird = 0; xid = 0;
  endtask

  initial begin
    int k;
    logic [4:0] order[$];
    idle_inputs();
    rst = 1'b1;
    m_cnt = 0; m_a = 0; m_d = 0; m_xacc = 0;
    repeat (2) @(negedge clk);
    chk("rst_we", {31'd0, rf_we_o}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr_o}, 32'd0);
    chk("rst_wdata", rf_wdata_o, 32'd0);
    chk("rst_wbrdy", {31'd0, wb_ready_o}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // WB write x5 = 0x11 on its own
    wbv = 1; wbwe = 1; wba = 5'd5; wbd = 32'h11;
    step();
    chk("wb_alone_rdy", {31'd0, s_wbrdy}, 32'd1);
    chk("wb_alone_we", {31'd0, rf_we_o}, 32'd1);
    chk("wb_alone_addr", {27'd0, rf_waddr_o}, 32'd5);
    chk("wb_alone_data", rf_wdata_o, 32'h11);
    idle_inputs();
    step();

    // Starvation: WB saturates, X-IF x7 = 0xAA waits until forced
    xiv = 1; xiwe = 1; xird = 5'd7; xid = 32'hAA;
    for (int i = 0; i <= FORCE_AT; i++) begin
      wbv = 1; wbwe = 1; wba = 5'(10 + i); wbd = 32'(i);
      step();
      chk("starve_wbrdy", {31'd0, s_wbrdy}, (i == FORCE_AT) ? 32'd0 : 32'd1);
      if (m_xacc) xiv = 0;
    end
    chk("starve_addr", {27'd0, rf_waddr_o}, 32'd7);
    chk("starve_data", rf_wdata_o, 32'hAA);
    chk("starve_we", {31'd0, rf_we_o}, 32'd1);
    // After the forced grant the counter restarts, so WB wins again.
    wba = 5'd20; wbd = 32'h20;
    xiv = 1; xird = 5'd8; xid = 32'hBB;
    step();
    chk("post_force_wbrdy", {31'd0, s_wbrdy}, 32'd1);
    if (m_xacc) xiv = 0;
    wbv = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (m_xacc) xiv = 0;
    end

    // X-IF result to x0 and a non-writing result: consumed without a write
    idle_inputs();
    xiv = 1; xiwe = 1; xird = 5'd0; xid = 32'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("x0_we", {31'd0, rf_we_o}, 32'd0);
      if (m_xacc) begin
        xiv = 0;
        chk("x0_handshake", {31'd0, s_xrdy}, 32'd1);
      end
    end
    xiv = 1; xiwe = 0; xird = 5'd9; xid = 32'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("xwe0_we", {31'd0, rf_we_o}, 32'd0);
      if (m_xacc) xiv = 0;
    end

    // A non-writing WB request does not block a pending X-IF result
    idle_inputs();
    wbv = 1; wbwe = 0; wba = 5'd3; wbd = 32'h33;
    xiv = 1; xiwe = 1; xird = 5'd4; xid = 32'h44;
    for (int i = 0; i < FORCE_AT - 2; i++) begin
      step();
      chk("wbnowe_rdy", {31'd0, s_wbrdy}, 32'd1);
      if (m_xacc) xiv = 0;
    end
    chk("wbnowe_addr", {27'd0, rf_waddr_o}, 32'd4);
    chk("wbnowe_data", rf_wdata_o, 32'h44);
    idle_inputs();
    step();

`ifdef CV32E40X_RF_ARB_XIF_BUF_EN
    // Three back-to-back results while WB saturates: fill, stall, drain in order
    k = 1;
    xiv = 1; xiwe = 1; xird = 5'd1; xid = 32'h101;
    for (int i = 0; i < 25; i++) begin
      wbv = 1; wbwe = 1; wba = 5'd20; wbd = 32'(i);
      step();
      if (i < 3) chk("fill_xrdy", {31'd0, s_xrdy}, (i == 2) ? 32'd0 : 32'd1);
      if (rf_we_o && rf_waddr_o != 5'd20) order.push_back(rf_waddr_o);
      if (m_xacc) begin
        k++;
        if (k <= 3) begin xird = 5'(k); xid = 32'(256 + k); end
        else xiv = 0;
      end
    end
    chk("drain_count", 32'(order.size()), 32'd3);
    for (int i = 0; i < 3 && i < order.size(); i++)
      chk("drain_order", {27'd0, order[i]}, 32'(i + 1));
    // Leave two results buffered for the reset check
    xiv = 1; xird = 5'd11; xid = 32'h111;
    step();
    xird = 5'd12; xid = 32'h112;
    step();
    xiv = 0;
    chk("prereset_full", 32'(mfifo.size()), 32'd2);
`else
    k = 0;
    order.delete();
`endif

    // Asynchronous reset in the middle of a cycle after a write
    wbv = 1; wbwe = 1; wba = 5'd6; wbd = 32'h66;
    step();
    chk("prereset_we", {31'd0, rf_we_o}, 32'd1);
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    chk("arst_we", {31'd0, rf_we_o}, 32'd0);
    chk("arst_waddr", {27'd0, rf_waddr_o}, 32'd0);
    chk("arst_wdata", rf_wdata_o, 32'd0);
    chk("arst_wbrdy", {31'd0, wb_ready_o}, 32'd1);
`ifdef CV32E40X_RF_ARB_XIF_BUF_EN
    chk("arst_xrdy", {31'd0, xif_result_ready_o}, 32'd0);
`endif
    mfifo.delete();
    m_cnt = 0; m_a = 0; m_d = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("postrst_nowrite", {31'd0, rf_we_o}, 32'd0);
    end

    // Random traffic; each X-IF result is held until the model sees it accepted
    for (int i = 0; i < 300; i++) begin
      wbv = 1'($urandom_range(0, 1));
      wbwe = ($urandom_range(0, 3) != 0);
      wba = 5'($urandom_range(0, 31));
      wbd = $urandom;
      if (!xiv && $urandom_range(0, 1) == 1) begin
        xiv = 1; xiwe = ($urandom_range(0, 3) != 0);
        xird = 5'($urandom_range(0, 31)); xid = $urandom;
      end
      step();
      if (m_xacc) xiv = 0;
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/cv32e40x_rf_wport_arbiter.md
CV32E40X_RF_WPORT_ARBITER -- requirements
Module: cv32e40x_rf_wport_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive cycles an X-IF result may lose arbitration before it is forced through (legal 1..15).
REQ-002 SHALL have port clk  input  1  clock, all state rising-edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have ports wb_valid_i  input  1 / wb_we_i  input  1 / wb_waddr_i  input  5 / wb_wdata_i  input  32  as the WB-stage write request.
REQ-005 SHALL have port wb_ready_o  output  1  meaning the WB request is accepted this cycle.
REQ-006 SHALL have ports xif_result_valid_i  input  1 / xif_result_we_i  input  1 / xif_result_rd_i  input  5 / xif_result_data_i  input  32  as the coprocessor result.
REQ-007 SHALL have port xif_result_ready_o  output  1  meaning the X-IF result handshake completes.
REQ-008 SHALL have ports rf_we_o  output  1 / rf_waddr_o  output  5 / rf_wdata_o  output  32  driving the single register-file write port.

Function
REQ-009 SHALL treat the WB side as requesting when wb_valid_i && wb_we_i, and the X-IF side as requesting when its head entry (xv) is valid.
REQ-010 SHALL grant WB by default when both request; X-IF granted whenever WB is not requesting.
REQ-011 SHALL keep a 4-bit starvation counter: +1 each cycle X-IF requests and loses; cleared on X-IF grant; saturates at STARVE_LIMIT.
REQ-012 SHALL force an X-IF grant when counter == STARVE_LIMIT and deassert wb_ready_o that cycle only.
REQ-013 SHALL drive wb_ready_o = 1 whenever not forced, including wb_valid_i=0 or wb_we_i=0 (a non-writing WB request consumes no port slot).
REQ-014 SHALL register the granted request: rf_we_o/rf_waddr_o/rf_wdata_o valid exactly 1 cycle after grant.
REQ-015 SHALL suppress rf_we_o for address 0 while still completing the granted handshake; X-IF results with xif_result_we_i=0 are consumed with rf_we_o=0.
REQ-016 SHALL drive rf_we_o=0 in any cycle following no grant; rf_waddr_o/rf_wdata_o hold their last values.
REQ-017 SHALL never grant both sides in one cycle; at most one RF write per cycle.

Reset
REQ-018 SHALL, on rst asserted (any cycle, asynchronously), clear counter, clear buffer, drive rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
REQ-019 SHALL drive wb_ready_o=1 and xif_result_ready_o=0 (buffered) during reset; results accepted but not yet written are discarded.
REQ-020 SHALL resume arbitration on the first clk edge after rst deasserts with no spurious write.

Configuration
REQ-021 SHALL use macro CV32E40X_RF_ARB_XIF_BUF_EN to include a 2-entry X-IF result FIFO.
REQ-022 SHALL, with the macro defined: push on xif_result_valid_i && xif_result_ready_o; xif_result_ready_o = !full (no same-cycle bypass when full); pop on X-IF grant; push into empty FIFO becomes eligible the next cycle; simultaneous push/pop with 1 entry keeps count 1; order strictly FIFO.
REQ-023 SHALL, with the macro undefined: xv = xif_result_valid_i, xif_result_ready_o = X-IF grant (combinational), no buffer state.

Verification
REQ-024 SHALL cover: WB write x5=0x11 alone -> rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x11 one cycle later, wb_ready_o=1.
REQ-025 SHALL cover: WB and X-IF (x7=0xAA) request continuously, STARVE_LIMIT=4 -> WB granted 4 cycles, cycle 5 wb_ready_o=0 and x7=0xAA written next cycle, counter back to 0.
REQ-026 SHALL cover: X-IF result to x0 with we=1 -> handshake completes, rf_we_o stays 0.
REQ-027 SHALL cover (buffer on): 3 back-to-back X-IF results while WB saturates -> xif_result_ready_o=0 after 2 pushes; drain in order x1,x2,x3.
REQ-028 SHALL cover: rst asserted mid-cycle with 2 buffered results -> rf_we_o=0 immediately, buffer empty, no write after release.
REQ-029 SHALL cover: wb_valid_i=1, wb_we_i=0 with X-IF pending -> X-IF granted same cycle, wb_ready_o=1.
